// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard-relevant pipeline state in, buffer enables/flushes/forward selects out.
// master = pipeline datapath side, slave = pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if;
   logic [3:0]  id_rs1, id_rs2;
   logic        id_use_rs1, id_use_rs2;
   logic        ex_wen, ex_load;
   logic [3:0]  ex_waddr;
   logic        mem_wen;
   logic [3:0]  mem_waddr;
   logic        br_taken, mem_req, dmem_ready, mem_halt, resume;
   logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic        if_id_flush, id_ex_flush;
   logic [1:0]  fwd_a, fwd_b;
   logic        halted;
   logic [15:0] stall_cnt;
   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_wen, ex_load, ex_waddr,
             mem_wen, mem_waddr, br_taken, mem_req, dmem_ready, mem_halt, resume,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
             fwd_a, fwd_b, halted, stall_cnt
   );
   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_wen, ex_load, ex_waddr,
             mem_wen, mem_waddr, br_taken, mem_req, dmem_ready, mem_halt, resume,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
             fwd_a, fwd_b, halted, stall_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: five-stage pipeline advance/hold/flush sequencing, forwarding selects, stall counter.
// Optional macro HAZ_FWD_EN: EX operand forwarding, so only load-use hazards stall.
module pipe_hazard_ctrl (
   input  logic              i_clk,
   input  logic              i_rst_n,
   pipe_hazard_ctrl_if.slave bus
);
   typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;
   state_t      r_state, w_next;
   logic [15:0] r_stall_cnt;
   logic        w_rd_ex, w_lu, w_raw, w_freeze;
   logic        w_pc_en, w_if_id_en, w_id_ex_en, w_down_en, w_if_id_flush, w_id_ex_flush;

   // Register 0 is hardwired, so a zero destination never matches.
   assign w_rd_ex = bus.ex_waddr != 4'd0 &&
                    ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_waddr) ||
                     (bus.id_use_rs2 && bus.id_rs2 == bus.ex_waddr));
   assign w_lu    = bus.ex_load && bus.ex_wen && w_rd_ex;
`ifdef HAZ_FWD_EN
   assign w_raw   = 1'b0;
`else
   logic w_rd_mem;
   assign w_rd_mem = bus.mem_waddr != 4'd0 &&
                     ((bus.id_use_rs1 && bus.id_rs1 == bus.mem_waddr) ||
                      (bus.id_use_rs2 && bus.id_rs2 == bus.mem_waddr));
   assign w_raw    = (bus.ex_wen && w_rd_ex) || (bus.mem_wen && w_rd_mem);
`endif
   assign w_freeze = (r_state == MEM_WAIT) ? !bus.dmem_ready
                   : (r_state == RUN) && bus.mem_req && !bus.dmem_ready;

   always_comb begin
      w_pc_en       = 1'b0;
      w_if_id_en    = 1'b0;
      w_id_ex_en    = 1'b0;
      w_down_en     = 1'b0;
      w_if_id_flush = 1'b0;
      w_id_ex_flush = 1'b0;
      w_next        = r_state;
      if (!i_rst_n) begin
         w_if_id_flush = 1'b1;
         w_id_ex_flush = 1'b1;
         w_next        = RUN;
      end else if (r_state == HALT) begin
         w_id_ex_en    = 1'b1;
         w_down_en     = 1'b1;
         w_id_ex_flush = 1'b1;
         w_next        = bus.resume ? RUN : HALT;
      end else if (w_freeze) begin
         w_next = MEM_WAIT;
      end else if (bus.mem_halt) begin
         w_id_ex_en    = 1'b1;
         w_down_en     = 1'b1;
         w_id_ex_flush = 1'b1;
         w_next        = HALT;
      end else if (bus.br_taken) begin
         w_pc_en       = 1'b1;
         w_if_id_en    = 1'b1;
         w_id_ex_en    = 1'b1;
         w_down_en     = 1'b1;
         w_if_id_flush = 1'b1;
         w_id_ex_flush = 1'b1;
         w_next        = RUN;
      end else begin
         w_pc_en       = !(w_lu || w_raw);
         w_if_id_en    = !(w_lu || w_raw);
         w_id_ex_en    = 1'b1;
         w_down_en     = 1'b1;
         w_id_ex_flush = w_lu || w_raw;
         w_next        = RUN;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_state     <= RUN;
         r_stall_cnt <= 16'd0;
      end else begin
         r_state <= w_next;
         if (!w_pc_en && r_state != HALT && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;
      end

`ifdef HAZ_FWD_EN
   logic [1:0] r_fwd_a, r_fwd_b, w_fwd_a, w_fwd_b;
   // The EX producer is younger than the MEM one, so it wins.
   assign w_fwd_a = (bus.ex_wen && bus.ex_waddr != 4'd0 && bus.ex_waddr == bus.id_rs1) ? 2'b01
                  : (bus.mem_wen && bus.mem_waddr != 4'd0 && bus.mem_waddr == bus.id_rs1) ? 2'b10 : 2'b00;
   assign w_fwd_b = (bus.ex_wen && bus.ex_waddr != 4'd0 && bus.ex_waddr == bus.id_rs2) ? 2'b01
                  : (bus.mem_wen && bus.mem_waddr != 4'd0 && bus.mem_waddr == bus.id_rs2) ? 2'b10 : 2'b00;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_fwd_a <= 2'b00;
         r_fwd_b <= 2'b00;
      end else if (w_id_ex_flush) begin
         r_fwd_a <= 2'b00;
         r_fwd_b <= 2'b00;
      end else if (w_id_ex_en) begin
         r_fwd_a <= w_fwd_a;
         r_fwd_b <= w_fwd_b;
      end
   assign bus.fwd_a = r_fwd_a;
   assign bus.fwd_b = r_fwd_b;
`else
   assign bus.fwd_a = 2'b00;
   assign bus.fwd_b = 2'b00;
`endif

   assign bus.pc_en       = w_pc_en;
   assign bus.if_id_en    = w_if_id_en;
   assign bus.id_ex_en    = w_id_ex_en;
   assign bus.ex_mem_en   = w_down_en;
   assign bus.mem_wb_en   = w_down_en;
   assign bus.if_id_flush = w_if_id_flush;
   assign bus.id_ex_flush = w_id_ex_flush;
   assign bus.halted      = r_state == HALT;
   assign bus.stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table vectors, directed hazard sequences and random stimulus
// against a rule-level reference model of the sequencing controller.
module tb_pipe_hazard_ctrl;
`ifdef HAZ_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   localparam int S_RUN = 0, S_MW = 1, S_HALT = 2;
   localparam logic [6:0] C_RST = 7'b0000011, C_FRZ = 7'b0000000, C_BUB = 7'b0011101,
                          C_BR = 7'b1111111, C_GO = 7'b1111100;

   typedef struct packed {
      logic [3:0] rs1, rs2;
      logic       u1, u2, ew, el;
      logic [3:0] ea;
      logic       mw;
      logic [3:0] ma;
      logic       br, req, rdy, halt, res;
   } in_t;
   typedef struct packed {
      in_t        in;
      logic [6:0] exp;
   } vec_t;

   logic clk = 1'b0, rst_n = 1'b0;
   int n_chk = 0, n_err = 0;
   int m_st = S_RUN;
   logic [1:0] m_fa = 2'b00, m_fb = 2'b00;
   logic [15:0] m_cnt = 16'd0;
   logic [6:0] dut_ctl_s;
   in_t cur, v;
   vec_t tbl[$];

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if bus();
   pipe_hazard_ctrl dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

   wire [6:0] dut_ctl = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                         bus.if_id_flush, bus.id_ex_flush};

   function automatic bit reads(in_t x, logic [3:0] r);
      return r != 4'd0 && ((x.u1 && x.rs1 == r) || (x.u2 && x.rs2 == r));
   endfunction

   function automatic bit frozen(in_t x, int st);
      return st == S_MW ? !x.rdy : (st == S_RUN && x.req && !x.rdy);
   endfunction

   // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
   function automatic logic [6:0] exp_ctl(in_t x, int st, logic rn);
      bit hz;
      if (!rn) return C_RST;
      if (st == S_HALT) return C_BUB;
      if (frozen(x, st)) return C_FRZ;
      if (x.halt) return C_BUB;
      if (x.br) return C_BR;
      hz = x.ew && reads(x, x.ea) && (x.el || !FWD);
      hz = hz || (!FWD && x.mw && reads(x, x.ma));
      return hz ? C_BUB : C_GO;
   endfunction

   function automatic logic [1:0] src(in_t x, logic [3:0] r);
      if (!FWD || r == 4'd0) return 2'b00;
      if (x.ew && x.ea == r) return 2'b01;
      if (x.mw && x.ma == r) return 2'b10;
      return 2'b00;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input in_t x);
      cur = x;
      bus.id_rs1 = x.rs1;  bus.id_rs2 = x.rs2;
      bus.id_use_rs1 = x.u1; bus.id_use_rs2 = x.u2;
      bus.ex_wen = x.ew; bus.ex_load = x.el; bus.ex_waddr = x.ea;
      bus.mem_wen = x.mw; bus.mem_waddr = x.ma;
      bus.br_taken = x.br; bus.mem_req = x.req; bus.dmem_ready = x.rdy;
      bus.mem_halt = x.halt; bus.resume = x.res;
   endtask

   task automatic chk_regs(input string tag);
      chk($sformatf("%s.fwd_a", tag), {14'd0, bus.fwd_a}, {14'd0, m_fa});
      chk($sformatf("%s.fwd_b", tag), {14'd0, bus.fwd_b}, {14'd0, m_fb});
      chk($sformatf("%s.halted", tag), {15'd0, bus.halted}, {15'd0, m_st == S_HALT});
      chk($sformatf("%s.stall_cnt", tag), bus.stall_cnt, m_cnt);
   endtask

   // Entered at posedge+1, checks at the falling edge, advances the model, returns at posedge+1.
   task automatic cycle(input string tag);
      logic [6:0] e;
      @(negedge clk);
      e = exp_ctl(cur, m_st, rst_n);
      dut_ctl_s = dut_ctl;
      chk($sformatf("%s.ctl", tag), {9'd0, dut_ctl}, {9'd0, e});
      chk_regs(tag);
      @(posedge clk);
      if (rst_n) begin
         if (!e[6] && m_st != S_HALT && m_cnt != 16'hFFFF) m_cnt++;
         if (e[0]) begin
            m_fa = 2'b00; m_fb = 2'b00;
         end else if (e[4]) begin
            m_fa = src(cur, cur.rs1); m_fb = src(cur, cur.rs2);
         end
         m_st = m_st == S_HALT ? (cur.res ? S_RUN : S_HALT)
              : frozen(cur, m_st) ? S_MW : (cur.halt ? S_HALT : S_RUN);
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m_st = S_RUN; m_fa = 2'b00; m_fb = 2'b00; m_cnt = 16'd0;
      #1;
      chk("rst.ctl_async", {9'd0, dut_ctl}, {9'd0, C_RST});
      chk_regs("rst.async");
      drive('0);
      cycle("rst");
      rst_n = 1'b1;
   endtask

   task automatic add(input in_t x, input logic [6:0] e);
      vec_t t;
      t.in = x; t.exp = e;
      tbl.push_back(t);
   endtask

   initial begin
      drive('0);
      #1;
      // RUN-state decision table, each vector applied fresh out of reset
      v = '0; add(v, C_GO);
      v = '0; v.req = 1; add(v, C_FRZ);
      v = '0; v.req = 1; v.rdy = 1; add(v, C_GO);
      v = '0; v.halt = 1; add(v, C_BUB);
      v = '0; v.br = 1; v.rs1 = 3; v.u1 = 1; v.ew = 1; v.el = 1; v.ea = 3; add(v, C_BR);
      v = '0; v.rs1 = 3; v.u1 = 1; v.ew = 1; v.el = 1; v.ea = 3; add(v, C_BUB);
      v = '0; v.rs2 = 7; v.ew = 1; v.el = 1; v.ea = 7; add(v, C_GO);
      v = '0; v.u1 = 1; v.ew = 1; v.el = 1; add(v, C_GO);
      v = '0; v.rs1 = 2; v.u1 = 1; v.ew = 1; v.ea = 2; add(v, FWD ? C_GO : C_BUB);
      v = '0; v.rs2 = 5; v.u2 = 1; v.mw = 1; v.ma = 5; add(v, FWD ? C_GO : C_BUB);
      v = '0; v.req = 1; v.halt = 1; v.br = 1; add(v, C_FRZ);
      v = '0; v.halt = 1; v.br = 1; add(v, C_BUB);
      v = '0; v.rs1 = 4; v.u1 = 1; v.el = 1; v.ea = 4; add(v, C_GO);
      v = '0; v.u2 = 1; v.mw = 1; add(v, C_GO);
      foreach (tbl[i]) begin
         do_reset();
         drive(tbl[i].in);
         cycle($sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d.table", i), {9'd0, dut_ctl_s}, {9'd0, tbl[i].exp});
      end

      // LDR r3 ; ADD r4,r3,r5
      do_reset();
      v = '0; v.rs1 = 3; v.rs2 = 5; v.u1 = 1; v.u2 = 1; v.ew = 1; v.el = 1; v.ea = 3;
      drive(v); cycle("lu1");
      chk("lu.bubble", {9'd0, dut_ctl_s}, {9'd0, C_BUB});
      v.ew = 0; v.el = 0; v.mw = 1; v.ma = 3;
      drive(v); cycle("lu2");
      if (!FWD) begin
         v.mw = 0; drive(v); cycle("lu3");
      end
      chk("lu.fwd_a", {14'd0, bus.fwd_a}, FWD ? 16'd2 : 16'd0);
      chk("lu.stall_cnt", bus.stall_cnt, FWD ? 16'd1 : 16'd2);

      // ADD r2 ; SUB r6,r2,r2
      do_reset();
      v = '0; v.rs1 = 2; v.rs2 = 2; v.u1 = 1; v.u2 = 1; v.ew = 1; v.ea = 2;
      drive(v); cycle("raw1");
      if (!FWD) begin
         v.ew = 0; v.mw = 1; v.ma = 2; drive(v); cycle("raw2");
         v.mw = 0; drive(v); cycle("raw3");
      end
      chk("raw.fwd_a", {14'd0, bus.fwd_a}, FWD ? 16'd1 : 16'd0);
      chk("raw.fwd_b", {14'd0, bus.fwd_b}, FWD ? 16'd1 : 16'd0);
      chk("raw.stall_cnt", bus.stall_cnt, FWD ? 16'd0 : 16'd2);

      // Taken branch squashes a coincident load-use
      do_reset();
      v = '0; v.br = 1; v.rs1 = 6; v.u1 = 1; v.ew = 1; v.el = 1; v.ea = 6;
      drive(v); cycle("brlu");
      chk("brlu.ctl", {9'd0, dut_ctl_s}, {9'd0, C_BR});
      chk("brlu.stall_cnt", bus.stall_cnt, 16'd0);

      // Three wait states then ready
      do_reset();
      v = '0; v.req = 1;
      for (int i = 0; i < 3; i++) begin
         drive(v); cycle("mw");
         chk("mw.frozen", {9'd0, dut_ctl_s}, {9'd0, C_FRZ});
      end
      v.rdy = 1; drive(v); cycle("mw_rdy");
      chk("mw_rdy.ctl", {9'd0, dut_ctl_s}, {9'd0, C_GO});
      chk("mw.stall_cnt", bus.stall_cnt, 16'd3);

      // Halt, idle in HALT, resume
      do_reset();
      v = '0; v.halt = 1; drive(v); cycle("halt");
      chk("halt.halted", {15'd0, bus.halted}, 16'd1);
      v = '0; v.br = 1;
      for (int i = 0; i < 3; i++) begin
         drive(v); cycle("halted");
         chk("halted.pc_en", {15'd0, dut_ctl_s[6]}, 16'd0);
      end
      v = '0; v.res = 1; drive(v); cycle("resume");
      chk("resume.halted", {15'd0, bus.halted}, 16'd0);
      chk("halt.stall_cnt", bus.stall_cnt, 16'd1);
      drive('0); cycle("post_resume");

      // Reset asserted mid MEM_WAIT
      do_reset();
      v = '0; v.req = 1; drive(v); cycle("mwr1"); cycle("mwr2");
      #2;
      do_reset();
      chk("mwr.stall_cnt", bus.stall_cnt, 16'd0);

      // Random traffic
      do_reset();
      for (int i = 0; i < 600; i++) begin
         v.rs1 = 4'($urandom_range(0, 3)); v.rs2 = 4'($urandom_range(0, 3));
         v.u1 = 1'($urandom); v.u2 = 1'($urandom);
         v.ew = 1'($urandom); v.el = ($urandom_range(0, 2) == 0);
         v.ea = 4'($urandom_range(0, 3)); v.mw = 1'($urandom); v.ma = 4'($urandom_range(0, 3));
         v.br = ($urandom_range(0, 6) == 0); v.req = ($urandom_range(0, 3) == 0);
         v.rdy = 1'($urandom); v.halt = ($urandom_range(0, 19) == 0);
         v.res = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 149) == 0) do_reset();
         drive(v);
         cycle("rnd");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
